// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory loaded over a ready/valid stream after reset, then
// serving registered fetches with a stall hold and a misaligned/out-of-program fault flag.
module imem_loadable #(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] NOP   = 32'h00000013,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          en,
  input  logic [31:0]   A,
  output logic [31:0]   RD,
  output logic          fault,
  output logic          run,
  output logic [IW:0]   count
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t      state_q, state_d;
  logic [IW:0] count_q, count_d;
  logic [31:0] rd_q, rd_d;
  logic        fault_q, fault_d;
  logic [31:0] mem [DEPTH];
  logic        accept, bad_addr;
  assign accept     = (state_q == LOAD) && load_valid;
  assign load_ready = (state_q == LOAD);
  assign run        = (state_q == RUN);
  assign count      = count_q;
  assign RD         = rd_q;
  assign fault      = fault_q;
  // full-width index compare so addresses past DEPTH fault instead of aliasing
  assign bad_addr   = (|A[1:0]) || (A[31:2] >= 30'(count_q));
  always_comb begin
    state_d = state_q;
    count_d = accept ? count_q + 1'b1 : count_q;
    if (state_q == IDLE) state_d = LOAD;
    else if (accept && (load_last || count_q == (IW+1)'(DEPTH - 1))) state_d = RUN;
    rd_d    = (state_q != RUN) ? NOP  : !en ? rd_q    : bad_addr ? NOP  : mem[A[IW+1:2]];
    fault_d = (state_q != RUN) ? 1'b0 : !en ? fault_q : bad_addr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q    <= NOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem[count_q[IW-1:0]] <= load_data;
  end
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: directed checks of boot, load, fetch, faults, stall, fill and reset.
module tb_imem_loadable;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 0, rst_n = 0;
  logic        load_valid = 0, load_last = 0, load_ready, en = 0, fault, run;
  logic [31:0] load_data = 0, A = 0, RD;
  logic [4:0]  count;
  int          total = 0, bad = 0;

  imem_loadable #(.DEPTH(16), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .en(en), .A(A), .RD(RD),
    .fault(fault), .run(run), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_f, input string tag);
    en = 1; A = addr;
    tick();
    chk({tag, "_rd"}, RD, exp_rd);
    chk({tag, "_fault"}, {31'b0, fault}, {31'b0, exp_f});
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_rd", RD, NOP);
    chk("rst_run", {31'b0, run}, 0);
    chk("rst_ready", {31'b0, load_ready}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_count", {27'b0, count}, 0);
    rst_n = 1;
    tick();
    chk("boot_ready", {31'b0, load_ready}, 1);
    // 3-word load with gaps in load_valid
    load_valid = 1; load_data = 32'h00500093;
    tick(); chk("gap_cnt1", {27'b0, count}, 1);
    load_valid = 0; load_data = 32'hDEADBEEF;
    tick(); chk("gap_cnt1b", {27'b0, count}, 1);
    load_valid = 1; load_data = 32'h00300113;
    tick(); chk("gap_cnt2", {27'b0, count}, 2);
    load_valid = 0;
    tick(); chk("gap_cnt2b", {27'b0, count}, 2);
    load_valid = 1; load_data = 32'h002081B3; load_last = 1; en = 1; A = 0;
    tick();
    chk("last_fetch_rd", RD, NOP);
    chk("last_fetch_fault", {31'b0, fault}, 0);
    chk("load_count", {27'b0, count}, 3);
    chk("load_run", {31'b0, run}, 1);
    chk("load_ready_off", {31'b0, load_ready}, 0);
    load_valid = 0; load_last = 0;
    fetch(0, 32'h00500093, 0, "f0");
    fetch(4, 32'h00300113, 0, "f4");
    fetch(8, 32'h002081B3, 0, "f8");
    fetch(12, NOP, 1, "f12_oor");
    fetch(32'h102, NOP, 1, "f102_mis");
    fetch(32'h40, NOP, 1, "f40_alias");
    fetch(4, 32'h00300113, 0, "stall_pre");
    en = 0; A = 0;
    tick(); chk("stall1_rd", RD, 32'h00300113); chk("stall1_fault", {31'b0, fault}, 0);
    tick(); chk("stall2_rd", RD, 32'h00300113);
    load_valid = 1; load_data = 32'h11111111;
    tick(); chk("run_ignores_load", {27'b0, count}, 3);
    load_valid = 0;
    // asynchronous reset mid-run, then fill the whole array
    rst_n = 0; #1;
    chk("rrun_rd", RD, NOP);
    chk("rrun_run", {31'b0, run}, 0);
    chk("rrun_count", {27'b0, count}, 0);
    tick(); rst_n = 1;
    tick();
    for (int i = 0; i < 20; i++) begin
      load_valid = 1; load_data = 32'h1000 + i;
      chk($sformatf("fill_ready%0d", i), {31'b0, load_ready}, (i < 16) ? 1 : 0);
      tick();
      chk($sformatf("fill_cnt%0d", i), {27'b0, count}, (i < 16) ? i + 1 : 16);
    end
    load_valid = 0;
    chk("fill_run", {31'b0, run}, 1);
    fetch(60, 32'h100F, 0, "fill_w15");
    fetch(0, 32'h1000, 0, "fill_w0");
    fetch(64, NOP, 1, "fill_past");
    // reset mid-load after 5 words
    en = 0;
    rst_n = 0; tick(); rst_n = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = 32'h2000 + i;
      tick();
    end
    chk("mid_cnt5", {27'b0, count}, 5);
    load_valid = 0;
    rst_n = 0; #1;
    chk("mid_rst_cnt", {27'b0, count}, 0);
    chk("mid_rst_ready", {31'b0, load_ready}, 0);
    chk("mid_rst_rd", RD, NOP);
    tick(); rst_n = 1;
    tick();
    load_valid = 1; load_last = 1; load_data = 32'h0000ABCD;
    tick();
    load_valid = 0; load_last = 0;
    chk("reload_cnt", {27'b0, count}, 1);
    fetch(4, NOP, 1, "reload_f4");
    fetch(0, 32'h0000ABCD, 0, "reload_f0");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
